// File: rtl/counter_pkg.sv
// Shared constants for the counter family: default width and the
// all-ones terminal value used to detect a wrap.
package counter_pkg;

    // Width used when the instantiating code does not override it.
    localparam int DEFAULT_WIDTH = 32;

    // All-ones value for a counter of the given width (1..64), returned
    // in 64 bits; callers truncate to their own width.
    function automatic logic [63:0] all_ones(input int width);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/counter_32bit.sv
// Free-running up counter with enable and a registered wrap indication.
// Optional build macro COUNTER_OVF_STICKY_EN: when defined, overflow sets on
// the first wrap and stays high until reset; otherwise it is a one-cycle
// pulse coincident with count returning to zero.
module counter_32bit
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    // Terminal value: the enabled edge that sees this value wraps to zero.
    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(all_ones(WIDTH));

    // A wrap happens only on an enabled edge at the terminal value.
    logic wrap;
    assign wrap = enable && (count == COUNT_MAX);

    // Counter and overflow registers; count has no next-state source other
    // than this increment so it can be forced and released in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (enable) begin
                count <= count + WIDTH'(1);
            end
`ifdef COUNTER_OVF_STICKY_EN
            if (wrap) begin
                overflow <= 1'b1;
            end
`else
            overflow <= wrap;
`endif
        end
    end

endmodule

// File: tb/tb_counter_32bit.sv
// Self-checking bench for counter_32bit: a 32-bit instance driven through a
// table of enable runs and hand-written reset/wrap sequences, plus a 4-bit
// instance for the narrow-width wrap.
module tb_counter_32bit;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        enable4;
    logic [31:0] count;
    logic        overflow;
    logic [3:0]  count4;
    logic        overflow4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    counter_32bit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .count    (count),
        .overflow (overflow)
    );

    counter_32bit #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable4),
        .count    (count4),
        .overflow (overflow4)
    );

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic [31:0] model_count;
    logic        model_ovf;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drives enable, predicts the next state,
    // lets one rising edge pass, then compares at the following falling edge.
    task automatic drive_edge(input string name, input logic en);
        logic [32:0] exp;
        logic        at_max;
        enable = en;
        at_max = (model_count == 32'hFFFF_FFFF);
`ifdef COUNTER_OVF_STICKY_EN
        model_ovf = model_ovf | (en & at_max);
`else
        model_ovf = en & at_max;
`endif
        if (en) begin
            model_count = model_count + 32'd1;
        end
        exp_q.push_back({model_ovf, model_count});
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check(name, {31'd0, overflow, count}, {31'd0, exp});
        end
    endtask

    // Hold reset for two cycles with enable low, release at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        enable  = 1'b0;
        enable4 = 1'b0;
        repeat (2) @(negedge clk);
        check("in_reset_count", {32'd0, count}, 64'd0);
        check("in_reset_ovf", {63'd0, overflow}, 64'd0);
        check("in_reset_count4", {60'd0, count4}, 64'd0);
        rst_n = 1'b1;
        model_count = '0;
        model_ovf   = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_reset_count", {32'd0, count}, 64'd0);
        check("post_reset_ovf", {63'd0, overflow}, 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        en;
        int          edges;
        logic [31:0] exp_count;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int pulses;
        rst_n       = 1'b0;
        enable      = 1'b0;
        enable4     = 1'b0;
        model_count = '0;
        model_ovf   = 1'b0;
        n_checks    = 0;
        n_pass      = 0;

        vecs[0] = '{name: "count20", en: 1'b1, edges: 20, exp_count: 32'h0000_0014, exp_ovf: 1'b0};
        vecs[1] = '{name: "hold5",   en: 1'b0, edges: 5,  exp_count: 32'h0000_0014, exp_ovf: 1'b0};
        vecs[2] = '{name: "count10", en: 1'b1, edges: 10, exp_count: 32'h0000_001E, exp_ovf: 1'b0};

        // Reset behaviour
        do_reset();

        // Table-driven count / hold runs
        foreach (vecs[v]) begin
            for (int e = 0; e < vecs[v].edges; e++) begin
                drive_edge(vecs[v].name, vecs[v].en);
            end
            check({vecs[v].name, "_final_count"}, {32'd0, count}, {32'd0, vecs[v].exp_count});
            check({vecs[v].name, "_final_ovf"}, {63'd0, overflow}, {63'd0, vecs[v].exp_ovf});
        end

        // Mid-count asynchronous reset: takes effect between clock edges
        for (int e = 0; e < 7; e++) begin
            drive_edge("precount", 1'b1);
        end
        enable = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_count", {32'd0, count}, 64'd0);
        check("async_reset_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        check("async_reset_hold", {32'd0, count}, 64'd0);
        rst_n = 1'b1;
        model_count = '0;
        model_ovf   = 1'b0;
        exp_q.delete();
        for (int e = 0; e < 20; e++) begin
            drive_edge("recount", 1'b1);
        end
        check("recount_final", {32'd0, count}, 64'h14);

        // Wrap: force near the top, release, count through the wrap
        force dut.count = 32'hFFFF_FFF0;
        #1;
        release dut.count;
        #1;
        check("forced_count", {32'd0, count}, 64'hFFFF_FFF0);
        model_count = 32'hFFFF_FFF0;
        for (int e = 0; e < 15; e++) begin
            drive_edge("to_max", 1'b1);
        end
        check("at_max_count", {32'd0, count}, 64'hFFFF_FFFF);
        check("at_max_ovf", {63'd0, overflow}, 64'd0);
        drive_edge("hold_at_max", 1'b0);
        check("hold_at_max_ovf", {63'd0, overflow}, 64'd0);
        drive_edge("wrap", 1'b1);
        check("wrap_count", {32'd0, count}, 64'd0);
        check("wrap_ovf", {63'd0, overflow}, 64'd1);
        drive_edge("after_wrap", 1'b1);
        check("after_wrap_count", {32'd0, count}, 64'd1);
`ifdef COUNTER_OVF_STICKY_EN
        check("after_wrap_ovf", {63'd0, overflow}, 64'd1);
`else
        check("after_wrap_ovf", {63'd0, overflow}, 64'd0);
`endif

        // 4-bit instance: 16 edges from zero give one wrap on the last edge
        do_reset();
        pulses = 0;
        for (int e = 1; e <= 16; e++) begin
            enable4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("w4_count", {60'd0, count4}, 64'(e % 16));
            if (overflow4) begin
                pulses++;
            end
            if (e == 16) begin
                check("w4_wrap_ovf", {63'd0, overflow4}, 64'd1);
            end else begin
                check("w4_no_ovf", {63'd0, overflow4}, 64'd0);
            end
        end
        enable4 = 1'b0;
        check("w4_final_count", {60'd0, count4}, 64'd0);
        check("w4_pulse_count", 64'(pulses), 64'd1);
        check("w4_other_idle", {32'd0, count}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_32bit.md
COUNTER_32BIT -- requirements
Module: counter_32bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the counter width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit; high means increment on this clock edge.
REQ-005 The block SHALL have port count, output, WIDTH bits, the current counter value, driven directly by the state register.
REQ-006 The block SHALL have port overflow, output, 1 bit, the registered wrap-around indication.

Function
REQ-007 On each rising clk edge with rst_n high and enable high, count SHALL become (count + 1) modulo 2^WIDTH.
REQ-008 On each rising clk edge with rst_n high and enable low, count SHALL hold its value.
REQ-009 Increment latency SHALL be one clock: a new count value is visible after the edge that samples enable high.
REQ-010 On an enabled edge where count equals all-ones (2^WIDTH-1), count SHALL wrap to 0 and overflow SHALL be 1 after that same edge.
REQ-011 After any other edge, overflow SHALL be 0 (default build), so overflow is a one-cycle pulse coincident with count = 0 after a wrap.
REQ-012 With enable low and count all-ones, no wrap SHALL occur and overflow SHALL stay 0.
REQ-013 count SHALL be a plain register with no other next-state sources, so a bench may force and release it; counting SHALL resume from the released value.
REQ-014 Arithmetic SHALL be unsigned, WIDTH bits; the carry out of the MSB is not stored anywhere other than overflow.
REQ-015 No combinational path SHALL exist from enable to count or overflow.

Reset
REQ-016 While rst_n is low, count SHALL be 0 and overflow SHALL be 0, independent of clk and enable.
REQ-017 Assertion of rst_n SHALL take effect immediately (asynchronous), including mid-count.
REQ-018 The first enabled rising edge after rst_n deasserts SHALL produce count = 1.
REQ-019 The bench SHALL deassert rst_n away from the rising clk edge; the block has no reset synchronizer.

Configuration
REQ-020 The feature is overflow stickiness, controlled by the macro COUNTER_OVF_STICKY_EN.
REQ-021 Without COUNTER_OVF_STICKY_EN, overflow SHALL follow REQ-010/REQ-011 as a one-cycle pulse.
REQ-022 With COUNTER_OVF_STICKY_EN defined, overflow SHALL set on a wrap and remain 1 until rst_n is asserted.
REQ-023 Counting behaviour SHALL be identical in both builds.

Structure
REQ-024 A shared package counter_pkg SHALL hold the default-width constant (32) and the all-ones compare constant function or localparam derived from WIDTH.
REQ-025 The block SHALL be one module with no sub-modules; the next-state adder and compare are inline.

Verification
REQ-026 Reset check: rst_n=0 for 2 cycles, enable=0, then release -> count=0x00000000, overflow=0.
REQ-027 Count check: enable=1 for 20 rising edges from 0 -> count=0x00000014, overflow=0 throughout.
REQ-028 Hold check: from 0x14, enable=0 for 5 edges -> count stays 0x00000014; then enable=1 for 10 edges -> count=0x0000001E.
REQ-029 Mid-count reset check: assert rst_n during counting -> count=0 immediately, without waiting for a clk edge; release with enable=1 and apply 20 edges -> count=0x00000014.
REQ-030 Wrap check: force count=0xFFFFFFF0, release, enable=1 -> after 15 edges count=0xFFFFFFFF, overflow=0; edge 16 -> count=0x00000000, overflow=1; edge 17 -> count=1, overflow=0 (default build) or overflow=1 (COUNTER_OVF_STICKY_EN build).
REQ-031 Width check: WIDTH=4, enable=1 for 16 edges from 0 -> count=0x0, one overflow pulse on edge 16.
